// File: rtl/icmp_echo_responder.sv
// Store-and-forward ICMP echo responder on an 8-bit AXI-Stream Ethernet path.
// Buffers one frame, filters for Echo Requests to this station, replies with swapped addresses.
module icmp_echo_responder #(
    parameter int unsigned MAX_FRAME    = 1518,
    parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_00,
    parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0180,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int unsigned PULSE_CYCLES = 12_500_000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             ping_detect,
    output logic [CNT_W-1:0] ping_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned IDX_W = $clog2(MAX_FRAME + 1);
    localparam int unsigned AW    = (MAX_FRAME > 1) ? $clog2(MAX_FRAME) : 1;
    localparam int unsigned TMR_W = $clog2(PULSE_CYCLES + 2);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_DRAIN, S_CHECK, S_TX} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d, len_q, len_d, rd_q, rd_d;
    logic               rdy_q, rdy_d;
    logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [7:0]         tdata_q, tdata_d;
    logic [47:0]        dmac_q, dmac_d;
    logic [15:0]        etype_q, etype_d, csum_q, csum_d;
    logic [7:0]         verihl_q, verihl_d, proto_q, proto_d, itype_q, itype_d, icode_q, icode_d;
    logic [31:0]        dip_q, dip_d;
    logic [CNT_W-1:0]   ping_cnt_q, ping_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               ping_q, ping_d;
    logic [7:0]         mem_q [MAX_FRAME];

    logic               rx_hs_c, out_hs_c, mem_we_c, accept_c;
    logic [16:0]        csum_sum_c;
    logic [15:0]        csum_new_c;
    logic [IDX_W-1:0]   src_idx_c;
    logic [7:0]         tx_byte_c;

    assign rx_hs_c  = s_axis_tvalid && rdy_q;
    assign out_hs_c = tvalid_q && m_axis_tready;

    // Echo Request -> Reply changes the ICMP type word by 0x0800; fold the carry back in.
    assign csum_sum_c = {1'b0, csum_q} + 17'h0_0800;
    assign csum_new_c = csum_sum_c[15:0] + 16'(csum_sum_c[16]);

    assign accept_c = (len_q >= IDX_W'(42))
                   && ((dmac_q == LOCAL_MAC) || (ACCEPT_BCAST && (dmac_q == '1)))
                   && (etype_q == 16'h0800) && (verihl_q == 8'h45) && (proto_q == 8'h01)
                   && (dip_q == LOCAL_IP) && (itype_q == 8'h08) && (icode_q == 8'h00);

    // Reply byte at read index: swapped MACs/IPs, reply type and corrected checksum.
    always_comb begin
        src_idx_c = rd_q;
        if (rd_q < IDX_W'(6)) begin
            src_idx_c = rd_q + IDX_W'(6);
        end else if ((rd_q >= IDX_W'(26)) && (rd_q <= IDX_W'(29))) begin
            src_idx_c = rd_q + IDX_W'(4);
        end else if ((rd_q >= IDX_W'(30)) && (rd_q <= IDX_W'(33))) begin
            src_idx_c = rd_q - IDX_W'(4);
        end
        tx_byte_c = mem_q[src_idx_c[AW-1:0]];
        case (rd_q)
            IDX_W'(6):  tx_byte_c = LOCAL_MAC[47:40];
            IDX_W'(7):  tx_byte_c = LOCAL_MAC[39:32];
            IDX_W'(8):  tx_byte_c = LOCAL_MAC[31:24];
            IDX_W'(9):  tx_byte_c = LOCAL_MAC[23:16];
            IDX_W'(10): tx_byte_c = LOCAL_MAC[15:8];
            IDX_W'(11): tx_byte_c = LOCAL_MAC[7:0];
            IDX_W'(34): tx_byte_c = 8'h00;
            IDX_W'(36): tx_byte_c = csum_new_c[15:8];
            IDX_W'(37): tx_byte_c = csum_new_c[7:0];
            default:    ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        len_d      = len_q;
        rd_d       = rd_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        dmac_d     = dmac_q;
        etype_d    = etype_q;
        verihl_d   = verihl_q;
        proto_d    = proto_q;
        dip_d      = dip_q;
        itype_d    = itype_q;
        icode_d    = icode_q;
        csum_d     = csum_q;
        ping_cnt_d = ping_cnt_q;
        drop_cnt_d = drop_cnt_q;
        tmr_d      = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
        mem_we_c   = 1'b0;

        case (state_q)
            S_IDLE, S_RX: begin
                if (rx_hs_c) begin
                    mem_we_c = 1'b1;
                    if (n_q < IDX_W'(6))                              dmac_d   = {dmac_q[39:0], s_axis_tdata};
                    if ((n_q == IDX_W'(12)) || (n_q == IDX_W'(13)))   etype_d  = {etype_q[7:0], s_axis_tdata};
                    if (n_q == IDX_W'(14))                            verihl_d = s_axis_tdata;
                    if (n_q == IDX_W'(23))                            proto_d  = s_axis_tdata;
                    if ((n_q >= IDX_W'(30)) && (n_q <= IDX_W'(33)))   dip_d    = {dip_q[23:0], s_axis_tdata};
                    if (n_q == IDX_W'(34))                            itype_d  = s_axis_tdata;
                    if (n_q == IDX_W'(35))                            icode_d  = s_axis_tdata;
                    if ((n_q == IDX_W'(36)) || (n_q == IDX_W'(37)))   csum_d   = {csum_q[7:0], s_axis_tdata};
                    if (s_axis_tlast) begin
                        len_d   = n_q + IDX_W'(1);
                        n_d     = '0;
                        state_d = S_CHECK;
                    end else if (n_q == IDX_W'(MAX_FRAME - 1)) begin
                        n_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        n_d     = n_q + IDX_W'(1);
                        state_d = S_RX;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_hs_c && s_axis_tlast) begin
                    drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
                    state_d    = S_IDLE;
                end
            end
            S_CHECK: begin
                if (accept_c) begin
                    ping_cnt_d = (&ping_cnt_q) ? ping_cnt_q : ping_cnt_q + CNT_W'(1);
                    tmr_d      = TMR_W'(PULSE_CYCLES);
                    rd_d       = '0;
                    tvalid_d   = 1'b0;
                    tlast_d    = 1'b0;
                    state_d    = S_TX;
                end else begin
                    drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
                    state_d    = S_IDLE;
                end
            end
            S_TX: begin
                if (out_hs_c && tlast_q) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = S_IDLE;
                end else if (!tvalid_q || out_hs_c) begin
                    tdata_d  = tx_byte_c;
                    tvalid_d = 1'b1;
                    tlast_d  = (rd_q == len_q - IDX_W'(1));
                    rd_d     = rd_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d  = (state_d == S_IDLE) || (state_d == S_RX) || (state_d == S_DRAIN);
        ping_d = (tmr_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            len_q      <= '0;
            rd_q       <= '0;
            rdy_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            dmac_q     <= '0;
            etype_q    <= '0;
            verihl_q   <= '0;
            proto_q    <= '0;
            dip_q      <= '0;
            itype_q    <= '0;
            icode_q    <= '0;
            csum_q     <= '0;
            ping_cnt_q <= '0;
            drop_cnt_q <= '0;
            tmr_q      <= '0;
            ping_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            len_q      <= len_d;
            rd_q       <= rd_d;
            rdy_q      <= rdy_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            dmac_q     <= dmac_d;
            etype_q    <= etype_d;
            verihl_q   <= verihl_d;
            proto_q    <= proto_d;
            dip_q      <= dip_d;
            itype_q    <= itype_d;
            icode_q    <= icode_d;
            csum_q     <= csum_d;
            ping_cnt_q <= ping_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            tmr_q      <= tmr_d;
            ping_q     <= ping_d;
        end
    end

    // Frame buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[n_q[AW-1:0]] <= s_axis_tdata;
        end
    end

    assign s_axis_tready = rdy_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign ping_detect   = ping_q;
    assign ping_count    = ping_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Self-checking bench for icmp_echo_responder: directed cases plus randomized frames
// checked against a byte-queue reference model of the echo rules.
module tb_icmp_echo_responder;

    localparam int unsigned MAXF  = 64;
    localparam int unsigned PULSE = 100;
    localparam int unsigned CW    = 16;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_00;
    localparam logic [31:0] LIP   = 32'hC0A8_0180;
    localparam logic [47:0] SMAC  = 48'hAA_BB_CC_DD_EE_01;
    localparam logic [31:0] SIP   = 32'hC0A8_0132;
    localparam logic [87:0] HELLO = "Hello World";

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic          ping_det;
    logic [CW-1:0] ping_cnt;
    logic [CW-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ping = 0;
    int exp_drop = 0;

    logic [7:0] tx_frame[$];
    logic [7:0] rx_bytes[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] saved[$];

    always #5 clk = ~clk;

    icmp_echo_responder #(
        .MAX_FRAME(MAXF), .LOCAL_MAC(LMAC), .LOCAL_IP(LIP),
        .ACCEPT_BCAST(1'b1), .PULSE_CYCLES(PULSE), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .ping_detect(ping_det), .ping_count(ping_cnt), .drop_count(drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_req(input logic [47:0] dmac, input logic [31:0] dip,
                             input logic [15:0] csum, input int plen);
        logic [15:0] tot;
        tot = 16'(28 + plen);
        tx_frame.delete();
        for (int k = 0; k < 6; k++) tx_frame.push_back(dmac[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) tx_frame.push_back(SMAC[47-8*k -: 8]);
        tx_frame.push_back(8'h08); tx_frame.push_back(8'h00);
        tx_frame.push_back(8'h45); tx_frame.push_back(8'h00);
        tx_frame.push_back(tot[15:8]); tx_frame.push_back(tot[7:0]);
        for (int k = 0; k < 4; k++) tx_frame.push_back(8'($urandom));
        tx_frame.push_back(8'h40); tx_frame.push_back(8'h01);
        tx_frame.push_back(8'($urandom)); tx_frame.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) tx_frame.push_back(SIP[31-8*k -: 8]);
        for (int k = 0; k < 4; k++) tx_frame.push_back(dip[31-8*k -: 8]);
        tx_frame.push_back(8'h08); tx_frame.push_back(8'h00);
        tx_frame.push_back(csum[15:8]); tx_frame.push_back(csum[7:0]);
        for (int k = 0; k < 4; k++) tx_frame.push_back(8'($urandom));
        for (int k = 0; k < plen; k++)
            tx_frame.push_back((k < 11) ? HELLO[8*(10-k) +: 8] : 8'($urandom));
    endtask

    // Reference: accept decision straight from the filter rules.
    function automatic bit model_accept();
        int n;
        logic [47:0] d;
        logic [31:0] ip;
        n = tx_frame.size();
        if (n < 42 || n > int'(MAXF)) return 1'b0;
        d = '0; ip = '0;
        for (int k = 0; k < 6; k++) d = {d[39:0], tx_frame[k]};
        for (int k = 30; k < 34; k++) ip = {ip[23:0], tx_frame[k]};
        if (!(d == LMAC || d == 48'hFFFF_FFFF_FFFF)) return 1'b0;
        if (tx_frame[12] != 8'h08 || tx_frame[13] != 8'h00) return 1'b0;
        if (tx_frame[14] != 8'h45 || tx_frame[23] != 8'h01) return 1'b0;
        if (ip != LIP) return 1'b0;
        if (tx_frame[34] != 8'h08 || tx_frame[35] != 8'h00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reply();
        int s;
        exp_bytes = tx_frame;
        for (int k = 0; k < 6; k++) begin
            exp_bytes[k]   = tx_frame[6+k];
            exp_bytes[6+k] = LMAC[47-8*k -: 8];
        end
        for (int k = 0; k < 4; k++) begin
            exp_bytes[26+k] = tx_frame[30+k];
            exp_bytes[30+k] = tx_frame[26+k];
        end
        exp_bytes[34] = 8'h00;
        s = int'({tx_frame[36], tx_frame[37]}) + 2048;
        if (s > 65535) s = s - 65535;
        exp_bytes[36] = 8'(s >> 8);
        exp_bytes[37] = 8'(s);
    endfunction

    task automatic send(input int gap_max, output int stalls, output bit timeout);
        int w;
        stalls = 0; timeout = 1'b0;
        for (int i = 0; i < tx_frame.size(); i++) begin
            if (gap_max > 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
            end
            s_tdata = tx_frame[i]; s_tvalid = 1'b1; s_tlast = (i == tx_frame.size() - 1);
            w = 0;
            while (!s_tready && w < 300) begin @(posedge clk); #1; w++; stalls++; end
            if (w >= 300) begin timeout = 1'b1; break; end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic collect(input bit bp, input int max_cycles, input int stop_after,
                           output int first_valid, output bit stable, output bit ended);
        bit prev_stall, hs;
        logic [7:0] prev_d;
        logic prev_l;
        rx_bytes.delete();
        first_valid = -1; stable = 1'b1; ended = 1'b0;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (prev_stall && (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l)) stable = 1'b0;
            if (m_tvalid && first_valid < 0) first_valid = c;
            if (stop_after >= 0 && rx_bytes.size() == stop_after) break;
            m_tready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata; prev_l = m_tlast;
            hs = m_tvalid && m_tready;
            if (hs) rx_bytes.push_back(m_tdata);
            @(posedge clk); #1;
            if (hs && prev_l) begin ended = 1'b1; break; end
        end
        m_tready = 1'b1;
    endtask

    task automatic run_frame(input string tag, input bit bp, input int gap);
        bit acc, drained, to, stable, ended;
        int stalls, first, nmis;
        acc = model_accept();
        drained = tx_frame.size() > MAXF;
        send(gap, stalls, to);
        check({tag, " rx_timeout"}, 64'(to), 64'(0));
        if (drained) check({tag, " drain_stalls"}, 64'(stalls), 64'(0));
        check({tag, " tready_after_rx"}, 64'(s_tready), drained ? 64'(1) : 64'(0));
        collect(bp, acc ? 400 : 20, -1, first, stable, ended);
        if (acc) begin
            model_reply();
            nmis = 0;
            for (int k = 0; k < exp_bytes.size(); k++)
                if (k >= rx_bytes.size() || rx_bytes[k] !== exp_bytes[k]) nmis++;
            check({tag, " reply_len"}, 64'(rx_bytes.size()), 64'(exp_bytes.size()));
            check({tag, " reply_bytes"}, 64'(nmis), 64'(0));
            check({tag, " tlast_seen"}, 64'(ended), 64'(1));
            check({tag, " latency"}, 64'(first), 64'(2));
            check({tag, " stall_stable"}, 64'(stable), 64'(1));
            check({tag, " tready_after_tx"}, 64'(s_tready), 64'(1));
            if (exp_ping < 65535) exp_ping++;
        end else begin
            check({tag, " no_output"}, 64'(first), 64'(-1));
            if (exp_drop < 65535) exp_drop++;
        end
        check({tag, " ping_count"}, 64'(ping_cnt), 64'(exp_ping));
        check({tag, " drop_count"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        bit stable, ended;
        int first, mode, plen, nmis;

        // Reset values
        #2;
        check("rst tready", 64'(s_tready), 64'(0));
        check("rst tvalid", 64'(m_tvalid), 64'(0));
        check("rst tlast", 64'(m_tlast), 64'(0));
        check("rst tdata", 64'(m_tdata), 64'(0));
        check("rst ping_detect", 64'(ping_det), 64'(0));
        check("rst counters", 64'({ping_cnt, drop_cnt}), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("tready after reset", 64'(s_tready), 64'(1));

        // Hello World request
        build_req(LMAC, LIP, 16'hAABB, 11);
        check("hello len", 64'(tx_frame.size()), 64'(53));
        saved = tx_frame;
        run_frame("hello", 1'b0, 0);
        check("hello byte0", 64'(rx_bytes[0]), 64'(8'hAA));
        check("hello mac", 64'({rx_bytes[6], rx_bytes[7], rx_bytes[8], rx_bytes[9], rx_bytes[10], rx_bytes[11]}), 64'(LMAC));
        check("hello sip", 64'({rx_bytes[26], rx_bytes[27], rx_bytes[28], rx_bytes[29]}), 64'(32'hC0A8_0180));
        check("hello dip", 64'({rx_bytes[30], rx_bytes[31], rx_bytes[32], rx_bytes[33]}), 64'(32'hC0A8_0132));
        check("hello type", 64'(rx_bytes[34]), 64'(0));
        check("hello csum", 64'({rx_bytes[36], rx_bytes[37]}), 64'(16'hB2BB));
        nmis = 0;
        for (int k = 0; k < 11; k++) if (rx_bytes[42+k] !== HELLO[8*(10-k) +: 8]) nmis++;
        check("hello payload", 64'(nmis), 64'(0));
        check("hello ping_detect", 64'(ping_det), 64'(1));
        check("hello ping_count", 64'(ping_cnt), 64'(1));
        exp_bytes = rx_bytes;

        // Same frame under random backpressure: identical byte stream
        tx_frame = saved;
        run_frame("hello_bp", 1'b1, 1);
        nmis = 0;
        for (int k = 0; k < exp_bytes.size(); k++) if (rx_bytes[k] !== exp_bytes[k]) nmis++;
        check("bp same_as_nobp", 64'(nmis), 64'(0));

        // Filter rejections
        build_req(LMAC, 32'hC0A8_0181, 16'hAABB, 11); run_frame("wrong_ip", 1'b0, 0);
        build_req(LMAC, LIP, 16'hAABB, 11); tx_frame[34] = 8'h00; run_frame("type0", 1'b0, 0);
        build_req(LMAC, LIP, 16'hAABB, 11); while (tx_frame.size() > 41) void'(tx_frame.pop_back());
        run_frame("len41", 1'b0, 0);
        check("three drops", 64'(drop_cnt), 64'(3));

        // Oversize frame drained, then an immediate ping
        build_req(LMAC, LIP, 16'h1234, 28);
        check("oversize len", 64'(tx_frame.size()), 64'(70));
        run_frame("oversize70", 1'b0, 0);
        build_req(LMAC, LIP, 16'hAABB, 11); run_frame("after_drain", 1'b0, 0);

        // Frame exactly MAX_FRAME long and one byte over
        build_req(LMAC, LIP, 16'h0F0F, 22); run_frame("len64", 1'b0, 0);
        build_req(LMAC, LIP, 16'h0F0F, 23); run_frame("len65", 1'b0, 0);

        // Checksum end-around carry; broadcast accepted
        build_req(LMAC, LIP, 16'hF800, 11); run_frame("csum_wrap", 1'b0, 0);
        check("csum F800", 64'({rx_bytes[36], rx_bytes[37]}), 64'(16'h0001));
        build_req(48'hFFFF_FFFF_FFFF, LIP, 16'h0001, 5); run_frame("bcast", 1'b1, 0);

        // Randomized frames
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(8, 0);
            plen = (mode == 8) ? $urandom_range(30, 23) : $urandom_range(22, 0);
            build_req((mode == 1) ? 48'({$urandom, $urandom}) : (mode == 2) ? 48'hFFFF_FFFF_FFFF : LMAC,
                      LIP, 16'($urandom), plen);
            if (mode == 3) tx_frame[12] = 8'h86;
            if (mode == 4) tx_frame[14] = 8'h46;
            if (mode == 5) tx_frame[23] = 8'h06;
            if (mode == 6) tx_frame[35] = 8'h01;
            if (mode == 7) while (tx_frame.size() > 20 + $urandom_range(21, 0)) void'(tx_frame.pop_back());
            run_frame($sformatf("rand%0d_m%0d", it, mode), 1'($urandom_range(1, 0)), $urandom_range(2, 0));
        end

        // Pulse expires after PULSE cycles with no new request
        repeat (PULSE + 10) @(posedge clk);
        #1;
        check("ping_detect expired", 64'(ping_det), 64'(0));

        // Reset in the middle of a reply
        build_req(LMAC, LIP, 16'hAABB, 11);
        send(0, first, ended);
        collect(1'b0, 200, 20, first, stable, ended);
        check("midtx bytes before reset", 64'(rx_bytes.size()), 64'(20));
        rst_n = 1'b0;
        #1;
        check("midtx tvalid", 64'(m_tvalid), 64'(0));
        check("midtx tlast", 64'(m_tlast), 64'(0));
        check("midtx counters", 64'({ping_cnt, drop_cnt}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ping = 0; exp_drop = 0;
        @(posedge clk); #1;
        check("tready after midtx reset", 64'(s_tready), 64'(1));
        build_req(LMAC, LIP, 16'hAABB, 11); run_frame("after_reset", 1'b0, 0);
        check("after_reset ping_detect", 64'(ping_det), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icmp_echo_responder.md
# icmp_echo_responder

Parametrised, store-and-forward ICMP echo responder on the 8-bit AXI-Stream Ethernet datapath between MAC RX and MAC TX. It buffers one whole frame and filters on local MAC, IPv4, local IP and ICMP Echo Request. For accepted frames it emits an Echo Reply with swapped addresses and an incrementally corrected ICMP checksum. It adds frame-size limits, drop/accept counters and a stretched activity pulse.

## Interface
- MAX_FRAME, 1518: buffer depth in bytes; larger frames dropped
- LOCAL_MAC, 48'h02_00_00_00_00_00: station MAC
- LOCAL_IP, 32'hC0A8_0180: station IPv4 address (192.168.1.128)
- ACCEPT_BCAST, 1: 1 = also accept dest MAC FF:FF:FF:FF:FF:FF
- PULSE_CYCLES, 12_500_000: ping_detect high time (100 ms at 125 MHz)
- CNT_W, 16: counter width

- clk  in  1  datapath clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  8  RX frame byte (byte 0 = first dest MAC byte)
- s_axis_tvalid  in  1  RX byte valid
- s_axis_tlast  in  1  RX last byte of frame
- s_axis_tready  out  1  RX accept
- m_axis_tdata  out  8  reply byte
- m_axis_tvalid  out  1  reply byte valid
- m_axis_tlast  out  1  reply last byte
- m_axis_tready  in  1  downstream accept
- ping_detect  out  1  stretched pulse per accepted request
- ping_count  out  CNT_W  accepted requests, saturating
- drop_count  out  CNT_W  dropped frames, saturating

## Operation
- States: IDLE, RX, DRAIN, CHECK, TX.
- IDLE/RX: s_axis_tready=1. Each accepted byte is written to the buffer at index n, with n counting from 0. Header fields are captured on the fly.
- If n reaches MAX_FRAME without tlast, go to DRAIN. DRAIN keeps tready=1 and discards bytes until tlast, then drops the frame and returns to IDLE.
- On the tlast beat, go to CHECK. This state lasts 1 cycle, tready=0, and evaluates the accept conditions:
  - length ≥ 42
  - dest MAC == LOCAL_MAC, or broadcast when ACCEPT_BCAST=1
  - bytes 12-13 = 0x0800
  - byte 14 = 0x45
  - byte 23 = 0x01
  - bytes 30-33 == LOCAL_IP
  - byte 34 = 0x08
  - byte 35 = 0x00
- Fail: drop_count++ and return to IDLE.
- Pass: ping_count++, (re)load the ping_detect timer, go to TX.
- TX streams len bytes from the buffer. tready=0 throughout. Substitutions by index:
  - 0-5: received src MAC (bytes 6-11)
  - 6-11: LOCAL_MAC
  - 26-29: received bytes 30-33
  - 30-33: received bytes 26-29
  - 34: 0x00
  - 36-37: new checksum
  - all other bytes are copied verbatim. The IP header checksum is unchanged because the address swap preserves the sum.
- Checksum: new = old + 0x0800 in 16-bit ones' complement, with end-around carry. Examples: 0xAABB→0xB2BB, 0xF800→0x0001.
- m_axis_tlast is asserted on byte len-1. After the final handshake, return to IDLE.
- Counters saturate at all-ones. A drop is counted once per frame.

## Timing
- Reset (async, immediate) values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, ping_detect=0, both counters 0, state IDLE. s_axis_tready goes to 1 on the first clk after rst_n deasserts.
- Assertion of rst_n=0 mid-RX or mid-TX aborts the frame. The output drops tvalid immediately and no partial tlast is emitted.
- Latency: first m_axis_tvalid occurs exactly 2 cycles after the RX tlast handshake (CHECK, then registered buffer read).
- AXI rules: tdata/tvalid/tlast hold stable while tvalid=1 and tready=0. The index advances only on tvalid&&tready. tvalid never drops mid-frame.
- s_axis_tready deasserts from CHECK until the cycle after the last TX handshake, then returns to 1.
- ping_detect: set in the cycle after CHECK passes and held for PULSE_CYCLES cycles. A new accept restarts the count.
- A 64-byte frame sent back-to-back with tready=1 produces 1 + 1 + 64 cycles until the next frame can start.

## Test plan
- 53-byte "Hello World" request to 02:00:00:00:00:00 / 192.168.1.128 with checksum 0xAABB → 53-byte reply. Required bytes:
  - byte 0 = 0xAA
  - bytes 6-11 = LOCAL_MAC
  - bytes 26-29 = C0 A8 01 80
  - bytes 30-33 = C0 A8 01 32
  - byte 34 = 0x00
  - bytes 36-37 = B2 BB
  - payload "Hello World"
  - tlast on byte 52, ping_detect=1, ping_count=1
- Same frame with dest IP C0A80181, then with byte 34=0x00, then with a 41-byte length → no m_axis_tvalid at all, drop_count=3.
- MAX_FRAME=64 and a 70-byte frame → tready stays 1 for all 70 bytes, no output, drop_count=1. An immediately following valid ping is answered correctly.
- Checksum 0xF800 in a request → reply bytes 36-37 = 00 01.
- m_axis_tready toggled pseudo-randomly during TX → output byte sequence identical to the no-backpressure case, with data held stable while stalled.
- rst_n pulsed low at TX byte 20 → m_axis_tvalid=0 immediately, counters 0. The next ping is fully answered.
